vga_bus_arbiter: RTL and testbench

- Shares the single VGA controller access port between two bus masters: requester 0 (CPU) and requester 1 (blitter/DMA).
- Accepts independent req/ack transactions from each master and decodes the target region from the address.
- Drives the controller's one-hot we_*/rd_* strobes, address and write data, then returns read data and an ack.
- Sits between the CPU/blitter bus and the VGA controller; at most one strobe is active in any cycle.

---
 rtl/vga_arb_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/vga_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_vga_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_arb_pkg
// Description : Region codes and FSM state encoding shared by the VGA bus
//               arbiter and its round-robin helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_arb_pkg;

    localparam logic [1:0] REG_TEXT   = 2'b00;
    localparam logic [1:0] REG_GRAPH  = 2'b01;
    localparam logic [1:0] REG_CURSOR = 2'b10;
    localparam logic [1:0] REG_REG    = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        ACK    = 2'd3
    } arb_state_t;

    // Text and graph memories are shared with the frame fetch; cursor/reg are not.
    function automatic logic busy_sensitive(input logic [1:0] region);
        return (region == REG_TEXT) || (region == REG_GRAPH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin pick; a lone requester always wins, a tie
//               goes to the side not granted last.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |eligible;
        grant = 1'b0;
        case (eligible)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vga_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_bus_arbiter
// Description : Shares the VGA controller access port between the CPU (0) and
//               the blitter (1). Optional macro VGA_ARB_BUSY_DEFER_EN defers
//               text/graph requests while the controller fetches the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_bus_arbiter
    import vga_arb_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int SEL_LSB = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        we_text,
    output logic        we_graph,
    output logic        we_cursor,
    output logic        we_reg,
    output logic        rd_text,
    output logic        rd_graph,
    output logic        rd_cursor,
    output logic        rd_reg,
    output logic [31:0] vga_addr,
    output logic [31:0] vga_wdata,
    input  logic [31:0] vga_rdata,
    input  logic        vga_busy
);

    localparam int             c_CNT_W    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic               r_grant;
    logic               r_last_grant;
    logic               r_wr;
    logic [1:0]         r_region;
    logic [c_CNT_W-1:0] r_cnt;

    logic [1:0]         w_region0;
    logic [1:0]         w_region1;
    logic [1:0]         w_eligible;
    logic               w_grant;
    logic               w_valid;
    logic               w_capture;
    logic               w_strobe_on;
    logic               w_ack_on;

    assign w_region0 = addr0[SEL_LSB+1:SEL_LSB];
    assign w_region1 = addr1[SEL_LSB+1:SEL_LSB];

`ifdef VGA_ARB_BUSY_DEFER_EN
    assign w_eligible[0] = req0 & ~(vga_busy & busy_sensitive(w_region0));
    assign w_eligible[1] = req1 & ~(vga_busy & busy_sensitive(w_region1));
`else
    logic w_unused_busy;
    assign w_unused_busy = vga_busy;
    assign w_eligible    = {req1, req0};
`endif

    rr_arb2 u_rr_arb2 (
        .eligible   (w_eligible),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .valid      (w_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_strobe_on = 1'b0;
        w_ack_on    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                w_strobe_on = 1'b1;
                if (r_wr) begin
                    w_next = ACK;
                end else if (RD_LAT == 0) begin
                    w_capture = 1'b1;
                    w_next    = ACK;
                end else begin
                    w_next = RDWAIT;
                end
            end
            RDWAIT: begin
                w_strobe_on = 1'b1;
                if (r_cnt == '0) begin
                    w_capture = 1'b1;
                    w_next    = ACK;
                end
            end
            ACK: begin
                w_ack_on = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Strobes decode from registered state only, so an async reset kills them at once.
    assign we_text   = w_strobe_on &  r_wr & (r_region == REG_TEXT);
    assign we_graph  = w_strobe_on &  r_wr & (r_region == REG_GRAPH);
    assign we_cursor = w_strobe_on &  r_wr & (r_region == REG_CURSOR);
    assign we_reg    = w_strobe_on &  r_wr & (r_region == REG_REG);
    assign rd_text   = w_strobe_on & ~r_wr & (r_region == REG_TEXT);
    assign rd_graph  = w_strobe_on & ~r_wr & (r_region == REG_GRAPH);
    assign rd_cursor = w_strobe_on & ~r_wr & (r_region == REG_CURSOR);
    assign rd_reg    = w_strobe_on & ~r_wr & (r_region == REG_REG);
    assign ack0      = w_ack_on & ~r_grant;
    assign ack1      = w_ack_on &  r_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_wr         <= 1'b0;
            r_region     <= REG_TEXT;
            r_cnt        <= '0;
            vga_addr     <= '0;
            vga_wdata    <= '0;
            rdata0       <= '0;
            rdata1       <= '0;
        end else begin
            if (r_state == IDLE && w_valid) begin
                r_grant      <= w_grant;
                r_last_grant <= w_grant;
                r_wr         <= w_grant ? wr1       : wr0;
                r_region     <= w_grant ? w_region1 : w_region0;
                vga_addr     <= w_grant ? addr1     : addr0;
                vga_wdata    <= w_grant ? wdata1    : wdata0;
            end
            if (r_state == ISSUE) begin
                r_cnt <= c_CNT_LOAD;
            end else if (r_state == RDWAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                if (r_grant) begin
                    rdata1 <= vga_rdata;
                end else begin
                    rdata0 <= vga_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_bus_arbiter
// Description : Self-checking bench for vga_bus_arbiter: transaction-timeline
//               reference model, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_bus_arbiter;

    localparam int RD_LAT  = 1;
    localparam int SEL_LSB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, wr0, wr1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        we_text, we_graph, we_cursor, we_reg;
    logic        rd_text, rd_graph, rd_cursor, rd_reg;
    logic [31:0] vga_addr, vga_wdata, vga_rdata;
    logic        vga_busy;

    vga_bus_arbiter #(.RD_LAT(RD_LAT), .SEL_LSB(SEL_LSB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .we_text(we_text), .we_graph(we_graph), .we_cursor(we_cursor), .we_reg(we_reg),
        .rd_text(rd_text), .rd_graph(rd_graph), .rd_cursor(rd_cursor), .rd_reg(rd_reg),
        .vga_addr(vga_addr), .vga_wdata(vga_wdata), .vga_rdata(vga_rdata),
        .vga_busy(vga_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // stimulus controls
    bit          rand_en   = 0;
    bit          busy_rand = 0;
    logic        busy_val  = 1'b0;
    bit          fix_rd_en = 0;
    logic [31:0] fix_rd    = '0;

    // reference model: one transaction timeline at a time
    bit          m_active;
    logic        m_g, m_wr, m_last;
    logic [1:0]  m_reg;
    logic [31:0] m_addr, m_wdata, m_cap;
    int          m_s;
    logic [31:0] exp_addr, exp_wdata;
    logic [31:0] exp_rdata [2];

    // DUT observations for the hand-computed checks
    int cnt_strb [8];
    int first_strb [8];
    int ack_cyc [2];
    int ack_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active     = 0;
        m_last       = 1'b1;
        m_cap        = '0;
        exp_addr     = '0;
        exp_wdata    = '0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 8; i++) begin
            cnt_strb[i]   = 0;
            first_strb[i] = -1;
        end
        ack_cyc[0] = -1;
        ack_cyc[1] = -1;
        ack_log.delete();
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.wr    = 1'($urandom_range(0, 1));
        t.addr  = $urandom();
        t.wdata = $urandom();
        return t;
    endfunction

    task automatic step();
        logic [7:0] obs, exp_s;
        logic [1:0] exp_ack, el, r;
        logic       w;
        int         lat;
        @(negedge clk);
        obs     = {rd_reg, rd_cursor, rd_graph, rd_text, we_reg, we_cursor, we_graph, we_text};
        exp_s   = '0;
        exp_ack = '0;
        lat     = m_wr ? 0 : RD_LAT;
        if (m_active) begin
            if (cyc == m_s + 1) begin
                exp_addr  = m_addr;
                exp_wdata = m_wdata;
            end
            if (cyc >= m_s + 1 && cyc <= m_s + 1 + lat)
                exp_s[(m_wr ? 0 : 4) + int'(m_reg)] = 1'b1;
            if (cyc == m_s + 2 + lat) begin
                exp_ack[m_g] = 1'b1;
                if (!m_wr) exp_rdata[m_g] = m_cap;
            end
        end
        chk("strobes",    32'(obs), 32'(exp_s));
        chk("one_strobe", 32'($countones(obs) <= 1), 32'd1);
        chk("acks",       32'({ack1, ack0}), 32'(exp_ack));
        chk("vga_addr",   vga_addr,  exp_addr);
        chk("vga_wdata",  vga_wdata, exp_wdata);
        chk("rdata0",     rdata0, exp_rdata[0]);
        chk("rdata1",     rdata1, exp_rdata[1]);

        for (int b = 0; b < 8; b++) begin
            if (obs[b]) begin
                cnt_strb[b]++;
                if (first_strb[b] < 0) first_strb[b] = cyc;
            end
        end
        if (ack0) begin ack_cyc[0] = cyc; ack_log.push_back(0); end
        if (ack1) begin ack_cyc[1] = cyc; ack_log.push_back(1); end

        // masters: retire on ack, optionally queue new work, present queue head
        if (exp_ack[0] && q0.size() > 0) void'(q0.pop_front());
        if (exp_ack[1] && q1.size() > 0) void'(q1.pop_front());
        if (rand_en && q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_txn());
        if (rand_en && q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_txn());
        req0 = (q0.size() > 0);
        req1 = (q1.size() > 0);
        if (req0) begin wr0 = q0[0].wr; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
        if (req1) begin wr1 = q1[0].wr; addr1 = q1[0].addr; wdata1 = q1[0].wdata; end
        vga_rdata = fix_rd_en ? fix_rd : $urandom();
        vga_busy  = busy_rand ? 1'($urandom_range(0, 1)) : busy_val;

        if (m_active) begin
            if (!m_wr && cyc == m_s + 1 + RD_LAT) m_cap = vga_rdata;
            if (cyc == m_s + 2 + lat) m_active = 0;
        end else begin
            el = {req1, req0};
`ifdef VGA_ARB_BUSY_DEFER_EN
            r = addr0[SEL_LSB+:2];
            if (vga_busy && r < 2'd2) el[0] = 1'b0;
            r = addr1[SEL_LSB+:2];
            if (vga_busy && r < 2'd2) el[1] = 1'b0;
`else
            r = 2'd0;
`endif
            if (el != 2'b00) begin
                w        = (el == 2'b11) ? ~m_last : el[1];
                m_last   = w;
                m_g      = w;
                m_wr     = w ? wr1 : wr0;
                m_addr   = w ? addr1 : addr0;
                m_wdata  = w ? wdata1 : wdata0;
                m_reg    = m_addr[SEL_LSB+:2];
                m_s      = cyc;
                m_active = 1;
            end
        end
        cyc++;
    endtask

    int t0, tb;

    initial begin
        rst = 1'b0;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        vga_rdata = '0; vga_busy = 1'b0;
        model_reset();
        clear_obs();
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({rd_reg, rd_cursor, rd_graph, rd_text, we_reg, we_cursor, we_graph, we_text}), 32'd0);
        chk("rst_acks", 32'({ack1, ack0}), 32'd0);
        chk("rst_vga_addr", vga_addr, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        rst = 1'b1;
        repeat (3) step();

        // single CPU graph write
        t0 = cyc;
        q0.push_back('{1'b1, 32'h0001_0040, 32'hDEAD_BEEF});
        clear_obs();
        repeat (5) step();
        chk("t1_we_graph_cnt", cnt_strb[1], 1);
        chk("t1_we_graph_cyc", first_strb[1], t0 + 1);
        chk("t1_ack0_cyc", ack_cyc[0], t0 + 2);
        chk("t1_vga_addr", vga_addr, 32'h0001_0040);
        chk("t1_vga_wdata", vga_wdata, 32'hDEAD_BEEF);

        // blitter text read with a known controller value
        fix_rd_en = 1; fix_rd = 32'h1234_5678;
        t0 = cyc;
        q1.push_back('{1'b0, 32'h0000_0010, 32'h0});
        clear_obs();
        repeat (6) step();
        fix_rd_en = 0;
        chk("t2_rd_text_cnt", cnt_strb[4], 2);
        chk("t2_rd_text_cyc", first_strb[4], t0 + 1);
        chk("t2_ack1_cyc", ack_cyc[1], t0 + 3);
        chk("t2_rdata1", rdata1, 32'h1234_5678);
        chk("t2_rdata0", rdata0, 32'h0);

        // asynchronous reset while a read waits on the controller
        q0.push_back('{1'b0, 32'h0002_0000, 32'h0});
        clear_obs();
        repeat (3) step();
        chk("t5_rd_cursor_before", 32'(rd_cursor), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("t5_rd_cursor_drop", 32'(rd_cursor), 32'd0);
        chk("t5_acks", 32'({ack1, ack0}), 32'd0);
        chk("t5_vga_addr", vga_addr, 32'd0);
        chk("t5_rdata0", rdata0, 32'd0);
        chk("t5_rdata1", rdata1, 32'd0);
        q0.delete(); q1.delete();
        req0 = 0; req1 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // simultaneous reg writes out of reset
        t0 = cyc;
        q0.push_back('{1'b1, 32'h0003_0000, 32'hAAAA_0000});
        q1.push_back('{1'b1, 32'h0003_0004, 32'hBBBB_0001});
        clear_obs();
        repeat (8) step();
        chk("t3_we_reg_cnt", cnt_strb[3], 2);
        chk("t3_we_reg_first", first_strb[3], t0 + 1);
        chk("t3_ack_n", ack_log.size(), 2);
        chk("t3_first_ack", ack_log.size() > 0 ? ack_log[0] : -1, 0);
        chk("t3_second_ack", ack_log.size() > 1 ? ack_log[1] : -1, 1);
        chk("t3_ack1_cyc", ack_cyc[1], t0 + 5);

        // both masters busy for six transactions
        for (int i = 0; i < 3; i++) begin
            q0.push_back(rand_txn());
            q1.push_back(rand_txn());
        end
        clear_obs();
        repeat (30) step();
        chk("t4_ack_n", ack_log.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("t4_alternate", ack_log.size() > i ? ack_log[i] : -1, i % 2);

`ifdef VGA_ARB_BUSY_DEFER_EN
        busy_val = 1'b1;
        t0 = cyc;
        q0.push_back('{1'b1, 32'h0001_0000, 32'h0000_00A0});
        q1.push_back('{1'b1, 32'h0002_0000, 32'h0000_00B1});
        clear_obs();
        repeat (8) step();
        busy_val = 1'b0;
        tb = cyc;
        repeat (5) step();
        chk("t6_first_ack", ack_log.size() > 0 ? ack_log[0] : -1, 1);
        chk("t6_we_cursor_cyc", first_strb[2], t0 + 1);
        chk("t6_we_graph_cyc", first_strb[1], tb + 1);
`else
        tb = cyc;
`endif

        // randomized traffic
        busy_rand = 1;
        rand_en   = 1;
        repeat (3000) step();
        rand_en   = 0;
        busy_rand = 0;
        busy_val  = 1'b0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
